// File: rtl/color_matrix_inverse_pkg.sv
// ---------------------------------------------------------------------------
// color_matrix_inverse_pkg
// Shared constants for the colour-matrix inverse block:
//   - default data / coefficient / fraction widths
//   - coefficient address map (address = 3*row + col)
//   - identity reset value for the coefficient banks
// ---------------------------------------------------------------------------
package color_matrix_inverse_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int MSIZE_DEF = 8;
  localparam int FRAC_DEF  = 5;

  localparam int COEF_NUM = 9;

  localparam int ADDR_M00 = 0;
  localparam int ADDR_M01 = 1;
  localparam int ADDR_M02 = 2;
  localparam int ADDR_M10 = 3;
  localparam int ADDR_M11 = 4;
  localparam int ADDR_M12 = 5;
  localparam int ADDR_M20 = 6;
  localparam int ADDR_M21 = 7;
  localparam int ADDR_M22 = 8;

  // First address past the coefficient map; writes at or above it are dropped.
  localparam logic [3:0] ADDR_LIMIT = 4'd9;

  // Identity matrix: diagonal = 1.0 (2^frac, positive sign), off-diagonal = 0.
  function automatic int identity_coef(input int addr, input int frac);
    if (addr == ADDR_M00 || addr == ADDR_M11 || addr == ADDR_M22) begin
      return 1 << frac;
    end
    return 0;
  endfunction

endpackage

// File: rtl/coef_dot3.sv
// ---------------------------------------------------------------------------
// coef_dot3
// One matrix row: res = clamp(round((m0*in0 + m1*in1 + m2*in2) / 2^FRAC)).
// Coefficients are sign-magnitude; inputs are two's complement.
// Four enable-gated stages; the result register is the last stage.
// Ports:
//   clock, rst_n   clock, async active-low reset (clears res only)
//   en             pipeline advance
//   in0..in2       signed DSIZE+1 bit components (L, A, B)
//   m0..m2         sign-magnitude MSIZE bit coefficients for this row
//   res            clamped unsigned DSIZE bit result
// ---------------------------------------------------------------------------
module coef_dot3
  import color_matrix_inverse_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int MSIZE = MSIZE_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic signed [DSIZE:0] in0,
  input  logic signed [DSIZE:0] in1,
  input  logic signed [DSIZE:0] in2,
  input  logic [MSIZE-1:0]      m0,
  input  logic [MSIZE-1:0]      m1,
  input  logic [MSIZE-1:0]      m2,
  output logic [DSIZE-1:0]      res
);

  localparam int PW = DSIZE + MSIZE;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] HALF    = SW'(1 << (FRAC - 1));
  localparam logic signed [SW-1:0] OUT_MAX = SW'((1 << DSIZE) - 1);

  // Round half toward +infinity, then drop the fraction bits.
  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s);
    return (s + HALF) >>> FRAC;
  endfunction

  function automatic logic [DSIZE-1:0] clamp_out(input logic signed [SW-1:0] v);
    if (v[SW-1]) begin
      return '0;
    end
    if (v > OUT_MAX) begin
      return '1;
    end
    return v[DSIZE-1:0];
  endfunction

  logic signed [DSIZE:0]   in_a [3];
  logic [MSIZE-1:0]        m_a  [3];
  logic signed [PW-1:0]    mag_prod [3];

  assign in_a[0] = in0;
  assign in_a[1] = in1;
  assign in_a[2] = in2;
  assign m_a[0]  = m0;
  assign m_a[1]  = m1;
  assign m_a[2]  = m2;

  // Magnitude is at most 2^(MSIZE-1)-1, so |product| fits in PW signed bits,
  // and so does its negation in the next stage.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      mag_prod[j] = PW'(in_a[j]) * PW'($signed({1'b0, m_a[j][MSIZE-2:0]}));
    end
  end

  logic signed [PW-1:0] mag_prod_p1 [3];
  logic [2:0]           sign_p1;
  logic signed [PW-1:0] sprod_p2 [3];
  logic signed [SW-1:0] sum01_p3;
  logic signed [PW-1:0] col2_p3;
  logic signed [SW-1:0] sum_all;

  always_ff @(posedge clock) begin
    if (en) begin
      // S1: magnitude products, coefficient signs captured with the sample
      for (int j = 0; j < 3; j++) begin
        mag_prod_p1[j] <= mag_prod[j];
        sign_p1[j]     <= m_a[j][MSIZE-1];
      end
      // S2: apply signs
      for (int j = 0; j < 3; j++) begin
        sprod_p2[j] <= sign_p1[j] ? -mag_prod_p1[j] : mag_prod_p1[j];
      end
      // S3: partial sum of columns 0 and 1, column 2 carried along
      sum01_p3 <= SW'(sprod_p2[0]) + SW'(sprod_p2[1]);
      col2_p3  <= sprod_p2[2];
    end
  end

  assign sum_all = sum01_p3 + SW'(col2_p3);

  // S4: final add, round, clamp into the output register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (en) begin
      res <= clamp_out(round_shift(sum_all));
    end
  end

endmodule

// File: rtl/color_matrix_inverse.sv
// ---------------------------------------------------------------------------
// color_matrix_inverse
// 3x3 sign-magnitude matrix applied to (L, A, B) producing clamped (R, G, B).
// Four-stage pipeline with a single global enable (valid/ready handshake).
// Coefficients are written into a shadow bank and copied into the active
// bank by a commit pulse; each sample captures the active coefficients at
// acceptance, so in-flight samples are unaffected by a commit.
// Ports:
//   clock, rst_n                 clock, async active-low reset
//   i_valid / i_ready            input handshake
//   iL, iA, iB                   signed DSIZE+1 bit components
//   o_valid / o_ready            output handshake
//   Ro, Go, Bo                   unsigned DSIZE bit components
//   coef_we, coef_addr,
//   coef_data                    shadow coefficient write (addr = 3*row+col)
//   coef_commit                  copy shadow bank into active bank
// ---------------------------------------------------------------------------
module color_matrix_inverse
  import color_matrix_inverse_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int MSIZE = MSIZE_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic signed [DSIZE:0] iL,
  input  logic signed [DSIZE:0] iA,
  input  logic signed [DSIZE:0] iB,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DSIZE-1:0]      Ro,
  output logic [DSIZE-1:0]      Go,
  output logic [DSIZE-1:0]      Bo,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  logic [MSIZE-1:0]      coef_data,
  input  logic                  coef_commit
);

  logic en;
  logic vld_p1, vld_p2, vld_p3;

  // The whole pipeline moves together; it stalls only when a valid output
  // is being refused downstream.
  assign en      = o_ready | ~o_valid;
  assign i_ready = en;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      o_valid <= 1'b0;
    end else if (en) begin
      vld_p1  <= i_valid;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      o_valid <= vld_p3;
    end
  end

  logic [MSIZE-1:0] shadow [COEF_NUM];
  logic [MSIZE-1:0] active [COEF_NUM];

  // Commit copies the shadow contents as they were before this edge, so a
  // write in the same cycle only reaches the shadow bank. Commit ignores en.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COEF_NUM; i++) begin
        shadow[i] <= MSIZE'(identity_coef(i, FRAC));
        active[i] <= MSIZE'(identity_coef(i, FRAC));
      end
    end else begin
      if (coef_commit) begin
        for (int i = 0; i < COEF_NUM; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (coef_we && (coef_addr < ADDR_LIMIT)) begin
        shadow[coef_addr] <= coef_data;
      end
    end
  end

  coef_dot3 #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC)) u_row_r (
    .clock (clock),
    .rst_n (rst_n),
    .en    (en),
    .in0   (iL),
    .in1   (iA),
    .in2   (iB),
    .m0    (active[ADDR_M00]),
    .m1    (active[ADDR_M01]),
    .m2    (active[ADDR_M02]),
    .res   (Ro)
  );

  coef_dot3 #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC)) u_row_g (
    .clock (clock),
    .rst_n (rst_n),
    .en    (en),
    .in0   (iL),
    .in1   (iA),
    .in2   (iB),
    .m0    (active[ADDR_M10]),
    .m1    (active[ADDR_M11]),
    .m2    (active[ADDR_M12]),
    .res   (Go)
  );

  coef_dot3 #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC)) u_row_b (
    .clock (clock),
    .rst_n (rst_n),
    .en    (en),
    .in0   (iL),
    .in1   (iA),
    .in2   (iB),
    .m0    (active[ADDR_M20]),
    .m1    (active[ADDR_M21]),
    .m2    (active[ADDR_M22]),
    .res   (Bo)
  );

endmodule

// File: tb/tb_color_matrix_inverse.sv
// ---------------------------------------------------------------------------
// tb_color_matrix_inverse
// Directed bench for color_matrix_inverse with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_color_matrix_inverse;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              i_valid;
  logic              i_ready;
  logic signed [8:0] iL, iA, iB;
  logic              o_valid;
  logic              o_ready;
  logic [7:0]        Ro, Go, Bo;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [7:0]        coef_data;
  logic              coef_commit;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rr, gg, bb;
  logic       v3, v4;
  logic [7:0] snap_r, snap_g, snap_b;
  logic [7:0] ct_exp [3];

  always #5 clock = ~clock;

  color_matrix_inverse dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .iL          (iL),
    .iA          (iA),
    .iB          (iB),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .Ro          (Ro),
    .Go          (Go),
    .Bo          (Bo),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic com);
    coef_we     = 1'b1;
    coef_addr   = a;
    coef_data   = d;
    coef_commit = com;
    tick();
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic commit_pulse();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  // One isolated sample with o_ready=1: v3 is o_valid after the 3rd edge,
  // v4 and the outputs are taken after the 4th edge.
  task automatic run_one(input logic [8:0] l, input logic [8:0] a, input logic [8:0] b);
    i_valid = 1'b1;
    iL = l;
    iA = a;
    iB = b;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    v3 = o_valid;
    tick();
    v4 = o_valid;
    rr = Ro;
    gg = Go;
    bb = Bo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int ct_got;
    int stale;

    rst_n       = 1'b0;
    i_valid     = 1'b0;
    iL          = '0;
    iA          = '0;
    iB          = '0;
    o_ready     = 1'b1;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    coef_commit = 1'b0;
    ct_exp      = '{8'd10, 8'd10, 8'd20};

    tick();
    tick();
    chk("reset_o_valid", o_valid, 0);
    chk("reset_Ro", Ro, 0);
    chk("reset_Go", Go, 0);
    chk("reset_Bo", Bo, 0);
    chk("reset_i_ready", i_ready, 1);
    rst_n = 1'b1;
    tick();

    // Identity after reset, with latency check
    run_one(9'd100, 9'd50, 9'd200);
    chk("lat_not_yet", v3, 0);
    chk("lat_valid", v4, 1);
    chk("ident_R", rr, 100);
    chk("ident_G", gg, 50);
    chk("ident_B", bb, 200);

    // Clamp at both ends
    run_one(9'h1FB, 9'h0FF, 9'h0FF);
    chk("clamp_lo_R", rr, 0);
    chk("clamp_G", gg, 255);
    chk("clamp_B", bb, 255);

    wr(4'd0, 8'h7F, 1'b0);
    commit_pulse();
    run_one(9'd255, 9'd20, 9'd30);
    chk("clamp_hi_R", rr, 255);
    chk("clamp_hi_G", gg, 20);
    chk("clamp_hi_B", bb, 30);

    // Rounding and sign handling: 1.5*3 = 4.5 -> 5
    wr(4'd0, 8'h30, 1'b0);
    commit_pulse();
    run_one(9'd3, 9'd0, 9'd0);
    chk("round_up_R", rr, 5);

    wr(4'd0, 8'hB0, 1'b0);
    commit_pulse();
    run_one(9'h1FD, 9'd0, 9'd0);
    chk("neg_neg_R", rr, 5);
    run_one(9'd3, 9'd0, 9'd0);
    chk("neg_pos_R", rr, 0);

    // Row G: 0.5*100 - 0.5*20 + 1.0*30 = 70
    wr(4'd3, 8'h10, 1'b0);
    wr(4'd4, 8'h90, 1'b0);
    wr(4'd5, 8'h20, 1'b0);
    commit_pulse();
    run_one(9'd100, 9'd20, 9'd30);
    chk("mix_R", rr, 0);
    chk("mix_G", gg, 70);
    chk("mix_B", bb, 30);

    // Backpressure: 8 samples, o_ready low in cycles 5..7
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sent = 0;
    got  = 0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      if (k >= 6 && k <= 8) begin
        chk("bp_hold_v", o_valid, 1);
        chk("bp_hold_R", Ro, snap_r);
        chk("bp_hold_G", Go, snap_g);
        chk("bp_hold_B", Bo, snap_b);
      end
      if (k == 5) begin
        snap_r = Ro;
        snap_g = Go;
        snap_b = Bo;
      end
      o_ready = !(k >= 5 && k <= 7);
      if (sent < 8) begin
        i_valid = 1'b1;
        iL = 9'(sent * 10 + 1);
        iA = 9'(sent * 3);
        iB = 9'(200 - sent);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (k >= 5 && k <= 7) begin
        chk("bp_i_ready_low", i_ready, 0);
      end
      if (o_valid && o_ready) begin
        chk("bp_R", Ro, 32'(got * 10 + 1));
        chk("bp_G", Go, 32'(got * 3));
        chk("bp_B", Bo, 32'(200 - got));
        got++;
      end
      if (i_valid && i_ready) begin
        sent++;
      end
      @(posedge clock);
      #1;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("bp_delivered", got, 8);
    chk("bp_sent", sent, 8);
    tick();
    tick();
    tick();
    tick();

    // Commit while two samples are in flight (identity active, shadow M00=2.0)
    wr(4'd0, 8'h40, 1'b0);
    ct_got = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_valid) begin
        if (ct_got < 3) begin
          chk("commit_R", Ro, ct_exp[ct_got]);
        end
        ct_got++;
      end
      i_valid     = (k < 3);
      iL          = 9'd10;
      iA          = 9'd0;
      iB          = 9'd0;
      coef_commit = (k == 1);
      tick();
    end
    i_valid     = 1'b0;
    coef_commit = 1'b0;
    chk("commit_count", ct_got, 3);

    // Write and commit in the same cycle: commit takes the pre-write shadow
    wr(4'd0, 8'h60, 1'b1);
    run_one(9'd10, 9'd0, 9'd0);
    chk("wr_commit_same_R", rr, 20);
    commit_pulse();
    run_one(9'd10, 9'd0, 9'd0);
    chk("wr_commit_later_R", rr, 30);

    // Reset with samples in flight
    i_valid = 1'b1;
    iL = 9'd77;
    iA = 9'd77;
    iB = 9'd77;
    tick();
    tick();
    tick();
    tick();
    i_valid = 1'b0;
    chk("pre_reset_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_Ro", Ro, 0);
    chk("midrst_Go", Go, 0);
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_valid) begin
        stale++;
      end
    end
    chk("midrst_no_stale", stale, 0);
    run_one(9'd10, 9'd20, 9'd30);
    chk("midrst_ident_R", rr, 10);
    chk("midrst_ident_G", gg, 20);
    chk("midrst_ident_B", bb, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
